seq_divmod: RTL
===============

Name: seq_divmod

Overview:
- Parametrised, multi-cycle unsigned divider that returns both quotient and remainder.
- Uses a start/busy/done handshake and flags divide-by-zero.
- Successor to the team's 4-bit combinational modulus block. Intended for the ALU datapath wherever WIDTH-bit mod/div is needed without a large combinational divider.
- Restoring division, one quotient bit per clock.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CW, $clog2(WIDTH+1), iteration counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division. Sampled only when busy=0.
- inputA  input  WIDTH  dividend. Captured on the accepted start edge.
- inputB  input  WIDTH  divisor. Captured on the accepted start edge.
- busy  output  1  operation in progress (CALC or DONE state).
- done  output  1  one-cycle pulse: results valid and updated.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder (A mod B).
- err  output  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Reset: on any rising edge with rst=1, all outputs and state clear.
  - state=IDLE; busy=0, done=0, err=0, quotient=0, remainder=0; counter and working registers 0.
  - Reset has priority over everything, including mid-operation and the done cycle. No done is produced for an aborted operation.
- States: IDLE, CALC, DONE. All outputs are registered.
- IDLE:
  - On an edge with start=1, latch inputA and inputB and set busy=1.
  - If inputB==0, go to DONE. Otherwise go to CALC with counter=0, partial remainder=0, and the shift register loaded with the dividend.
- CALC, one step per edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial subtract the divisor in WIDTH+1 bits. If the result is non-negative, keep it and shift in a quotient bit of 1; else restore and shift in 0.
  - After WIDTH steps (counter == WIDTH-1 on the stepping edge), go to DONE.
- DONE entry (same edge the state becomes DONE):
  - quotient, remainder and err update; done=1.
  - Next edge: go to IDLE, done=0, busy=0.
- Latency, counting rising edges from the start-sampling edge:
  - Normal operation: done rises at edge WIDTH+1 and stays high for exactly one cycle.
  - Divide-by-zero: done rises at edge 1.
  - Throughput: one operation per WIDTH+2 cycles.
- Divide-by-zero results: err=1, quotient = all ones, remainder = dividend. This mirrors the hardware fallback of the restoring algorithm.
- Normal completion: err=0.
- Holding: quotient, remainder and err hold their values until the next completion or reset.
- start while busy=1 (CALC or DONE) is ignored. It is not queued, and operands are not re-latched.
- inputA and inputB may change freely after the accepted edge; results depend only on the latched values.
- start may be asserted in the cycle after done falls (first IDLE cycle) and is accepted.
- Arithmetic is unsigned only.
  - dividend < divisor gives quotient=0, remainder=dividend.
  - divisor==1 gives quotient=dividend, remainder=0.
  - Maximum operands must not overflow. The internal partial remainder is WIDTH+1 bits.

Test Plan:
- WIDTH=4, A=4'b1111, B=4'b1010, start pulse → done at edge 5 after start: quotient=1, remainder=5, err=0. busy high on edges 1–5, low at edge 6.
- WIDTH=4, A=15, B=0 → done at edge 1: err=1, quotient=4'b1111, remainder=15. Then busy=0 at edge 2. Next A=7, B=9 → quotient=0, remainder=7, err clears to 0.
- WIDTH=8: A=200, B=7 → quotient=28, remainder=4. A=255, B=1 → quotient=255, remainder=0. A=255, B=255 → quotient=1, remainder=0.
- WIDTH=4, start A=13, B=4. Pulse start again with A=1, B=1 during CALC and during the DONE cycle → single done, quotient=3, remainder=1.
- Assert rst at edge 3 of a WIDTH=8 operation → next cycle all outputs 0, no done pulse. A new start after reset (A=100, B=9) gives quotient=11, remainder=1.
- Randomized back-to-back sweep, start issued in the first IDLE cycle after each done, WIDTH=4 exhaustive (256 pairs) → every result matches A/B and A%B. B=0 cases flagged per the divide-by-zero rule.

Source files
------------

// File: rtl/seq_divmod.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with a
// start/busy/done handshake and a divide-by-zero flag.
module seq_divmod #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] shreg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] shreg_nxt;

  // One restoring step; the trial subtract is WIDTH+1 bits wide so the
  // borrow (MSB) decides between keeping the difference and restoring.
  always_comb begin
    shifted   = {prem, shreg[WIDTH-1]};
    trial     = shifted - {1'b0, divisor};
    qbit      = ~trial[WIDTH];
    prem_nxt  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    shreg_nxt = {shreg[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      divisor   <= '0;
      prem      <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            divisor <= inputB;
            shreg   <= inputA;
            prem    <= '0;
            cnt     <= '0;
            if (inputB == '0) begin
              // Same result the restoring loop would produce with a zero divisor
              state     <= DONE;
              quotient  <= '1;
              remainder <= inputA;
              err       <= 1'b1;
              done      <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem  <= prem_nxt;
          shreg <= shreg_nxt;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            quotient  <= shreg_nxt;
            remainder <= prem_nxt;
            err       <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
